// File: rtl/wisc_pkg.sv
// ============================================================================
// Module      : wisc_pkg
// Description : Shared WISC definitions: opcode encodings, flag bit
//               positions and the {Z, V, N} flag vector type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wisc_pkg;

  // ISA opcode encodings
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // Flag bit positions; ordering {Z, V, N} matches branch resolution
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef logic [2:0] flags_t;

endpackage : wisc_pkg

`default_nettype wire

// File: rtl/flag_wr_decode.sv
// ============================================================================
// Module      : flag_wr_decode
// Description : Combinational opcode -> flag write-mask decoder. A set bit
//               means the opcode defines that flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_wr_decode
  import wisc_pkg::*;
(
  input  logic [3:0] opcode,
  output flags_t     wr_mask
);

  // Map each opcode onto the set of flags it is architecturally defined to set
  always_comb begin
    wr_mask = '0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        wr_mask[FLAG_Z] = 1'b1;
        wr_mask[FLAG_V] = 1'b1;
        wr_mask[FLAG_N] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        wr_mask[FLAG_Z] = 1'b1;
      end
      default: wr_mask = '0;
    endcase
  end

endmodule : flag_wr_decode

`default_nettype wire

// File: rtl/flag_unit.sv
// ============================================================================
// Module      : flag_unit
// Description : WISC {Z, V, N} flag register with same-cycle forwarding to
//               branch resolution, honouring stall, flush and halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_unit
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ex,
  input  logic [3:0]  opcode_ex,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        stall,
  input  logic        flush_ex,
  output logic [2:0]  F,
  output logic [2:0]  F_fwd,
  output logic        halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0] r_state;
  flags_t     r_flags;
  flags_t     w_mask;
  flags_t     w_new;
  flags_t     w_fwd;
  logic       w_retire;
  logic       w_we;

  flag_wr_decode u_flag_wr_decode (
    .opcode  (opcode_ex),
    .wr_mask (w_mask)
  );

  // An instruction truly leaves EX only when real, not frozen and not squashed
  assign w_retire = valid_ex & ~stall & ~flush_ex;
  assign w_we     = w_retire & (r_state == ST_RUN);

  // Candidate flag values; Z comes from the already-saturated ALU output
  always_comb begin
    w_new         = '0;
    w_new[FLAG_Z] = (alu_result == 16'h0000);
    w_new[FLAG_V] = alu_ovfl;
    w_new[FLAG_N] = alu_result[15];
  end

  // Per-flag forwarding mux: defined flags take the new value, others hold
  always_comb begin
    w_fwd = r_flags;
    for (int i = 0; i < 3; i++) begin
      if (w_we && w_mask[i]) begin
        w_fwd[i] = w_new[i];
      end
    end
  end

  // Architectural flag register: commits exactly what was forwarded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= w_fwd;
    end
  end

  // Halt FSM: a retiring HLT freezes the register until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_retire && (opcode_ex == OP_HLT)) r_state <= ST_HALT;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign F      = r_flags;
  assign F_fwd  = w_fwd;
  assign halted = (r_state == ST_HALT);

endmodule : flag_unit

`default_nettype wire
